mario_life_ctrl: RTL and testbench
==================================

MARIO_LIFE_CTRL -- requirements
Module: mario_life_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter LIVES_INIT, 3, lives loaded at reset and on restart (range 1..3).
REQ-003 Parameter INVULN_FRAMES, 90, frames of invulnerability after a non-fatal hit (range 2..255).
REQ-004 Parameter BLINK_HALF, 4, frames per visible/invisible half-period during invulnerability (power of two, at most INVULN_FRAMES).
REQ-005 clk  input  1  pixel clock, 25.175 MHz.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-008 mario_hit  input  1  one-cycle rising-edge pulse from the enemy collision detector.
REQ-009 restart  input  1  level-sampled new-game request.
REQ-010 lives  output  2  remaining lives.
REQ-011 invincible  output  1  high while in INVULN.
REQ-012 mario_visible  output  1  sprite enable for the Mario renderer.
REQ-013 hurt_pulse  output  1  one-cycle pulse per accepted hit (sound and knockback trigger).
REQ-014 game_over  output  1  high while in OVER.

Function
REQ-015 The block SHALL use states PLAY, INVULN and OVER, and all outputs SHALL be registered.
REQ-016 PLAY, mario_hit with lives>1: next cycle lives decrements by 1, state becomes INVULN, frame counter clears to 0, hurt_pulse is 1 for exactly one cycle.
REQ-017 PLAY, mario_hit with lives==1: next cycle lives becomes 0, state becomes OVER, hurt_pulse is 1 for one cycle.
REQ-018 INVULN: mario_hit SHALL be ignored and not queued; lives and hurt_pulse stay unchanged.
REQ-019 INVULN: each frame_tick increments the frame counter; the tick on which the counter equals INVULN_FRAMES-1 returns the state to PLAY next cycle.
REQ-020 A mario_hit coincident with that final tick SHALL be ignored.
REQ-021 mario_visible SHALL be 0 in INVULN when floor(frame counter / BLINK_HALF) is odd, and 1 at all other times, including PLAY and OVER.
REQ-022 OVER: mario_hit and frame_tick SHALL be ignored; lives holds 0; game_over holds 1.
REQ-023 restart in any state SHALL force, next cycle: PLAY, lives=LIVES_INIT, frame counter 0, invincible 0, hurt_pulse 0.
REQ-024 restart SHALL take priority over a coincident mario_hit or frame_tick.
REQ-025 The frame counter SHALL be $clog2(INVULN_FRAMES) bits wide and SHALL never wrap within INVULN.
REQ-026 lives SHALL never underflow below 0.
REQ-027 mario_hit asserted on consecutive cycles in PLAY SHALL cost exactly one life, because the second pulse lands in INVULN or OVER.

Reset
REQ-028 While rst_n is low: state PLAY, lives=LIVES_INIT, frame counter 0, invincible 0, mario_visible 1, hurt_pulse 0, game_over 0.
REQ-029 Reset SHALL take effect asynchronously, mid-INVULN or mid-OVER included, and release SHALL resume normal operation on the first clk edge after rst_n goes high.

Structure
REQ-030 State encoding and the LIVES_INIT, INVULN_FRAMES and BLINK_HALF defaults SHALL live in the shared package mario_pkg.
REQ-031 The block SHALL be a single module, with the INVULN frame counter in its own always block.
REQ-032 No sub-module is required.

Verification
REQ-033 Reset, then one hit -> lives 3->2, hurt_pulse one cycle, invincible=1, mario_visible=0 during frames 4-7, 12-15, ..., 84-87; PLAY after 90 ticks.
REQ-034 Three hits spaced 100 frames apart -> lives 2, 1, then 0; game_over=1 after the third; later hits produce no hurt_pulse.
REQ-035 Hits at frames 1, 30 and 89 of INVULN -> lives stays 2, no hurt_pulse; the hit coincident with the 90th tick is also ignored.
REQ-036 restart in OVER, then again coincident with a hit in PLAY -> lives=3 and state PLAY both times, no hurt_pulse.
REQ-037 rst_n asserted at INVULN frame 45 -> all outputs at reset values with no clock edge; after release, a hit gives lives 2.
REQ-038 mario_hit held high for 2 cycles in PLAY -> lives 3->2, exactly one hurt_pulse.

Source files
------------

// File: rtl/mario_pkg.sv
// Shared definitions for the Mario life/damage controller: state encoding and
// default tuning values for lives, invulnerability length and blink rate.
package mario_pkg;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_INVULN = 2'd1,
    ST_OVER   = 2'd2
  } mario_state_e;

  localparam int unsigned LIVES_INIT_DEF    = 3;
  localparam int unsigned INVULN_FRAMES_DEF = 90;
  localparam int unsigned BLINK_HALF_DEF    = 4;

endpackage

// File: rtl/mario_life_ctrl.sv
// Tracks Mario's remaining lives, the post-hit invulnerability window with
// sprite blinking, and game-over; every output comes straight from a flop.
module mario_life_ctrl
  import mario_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = LIVES_INIT_DEF,
  parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int unsigned BLINK_HALF    = BLINK_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       mario_hit,
  input  logic       restart,
  output logic [1:0] lives,
  output logic       invincible,
  output logic       mario_visible,
  output logic       hurt_pulse,
  output logic       game_over
);

  localparam int unsigned      CNT_W     = $clog2(INVULN_FRAMES);
  localparam int unsigned      BLINK_BIT = $clog2(BLINK_HALF);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);

  mario_state_e     state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hurt_d, visible_d;
  logic             invincible_q, visible_q, hurt_q, over_q;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    hurt_d  = 1'b0;
    if (restart) begin
      state_d = ST_PLAY;
      lives_d = LIVES_RST;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if (mario_hit) begin
            hurt_d = 1'b1;
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              state_d = ST_INVULN;
            end else begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end
          end
        end
        ST_INVULN: begin
          // Hits are dropped here, including one landing on the final tick.
          if (frame_tick && (cnt_q == CNT_LAST)) state_d = ST_PLAY;
        end
        ST_OVER: begin
          lives_d = 2'd0;
        end
        default: begin
          state_d = ST_PLAY;
          lives_d = LIVES_RST;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (state_q == ST_PLAY && mario_hit) begin
      cnt_d = '0;
    end else if (state_q == ST_INVULN && frame_tick) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Blink phase is taken from the next counter value so the registered
  // sprite enable lines up with the state it describes.
  always_comb begin
    visible_d = !((state_d == ST_INVULN) &&
                  (((cnt_d >> BLINK_BIT) & CNT_W'(1)) != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PLAY;
      lives_q      <= LIVES_RST;
      invincible_q <= 1'b0;
      visible_q    <= 1'b1;
      hurt_q       <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      invincible_q <= (state_d == ST_INVULN);
      visible_q    <= visible_d;
      hurt_q       <= hurt_d;
      over_q       <= (state_d == ST_OVER);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign lives         = lives_q;
  assign invincible    = invincible_q;
  assign mario_visible = visible_q;
  assign hurt_pulse    = hurt_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_mario_life_ctrl.sv
// Bench for mario_life_ctrl: directed scenarios plus random traffic, each
// cycle compared against a lives/elapsed-frames model of the game rules.
module tb_mario_life_ctrl;

  localparam int LI = 3;
  localparam int IF = 90;
  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       mario_hit = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] lives;
  logic       invincible, mario_visible, hurt_pulse, game_over;

  int errors = 0;
  int checks = 0;

  // Model: lives left, frames elapsed in the invulnerability window (-1 = none).
  int m_lives;
  int m_el;
  bit m_hurt;

  always #20 clk = ~clk;

  mario_life_ctrl #(
    .LIVES_INIT   (LI),
    .INVULN_FRAMES(IF),
    .BLINK_HALF   (BH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .mario_hit    (mario_hit),
    .restart      (restart),
    .lives        (lives),
    .invincible   (invincible),
    .mario_visible(mario_visible),
    .hurt_pulse   (hurt_pulse),
    .game_over    (game_over)
  );

  function automatic void m_reset();
    m_lives = LI;
    m_el    = -1;
    m_hurt  = 1'b0;
  endfunction

  function automatic void m_step(bit h, bit t, bit r);
    m_hurt = 1'b0;
    if (r) begin
      m_lives = LI;
      m_el    = -1;
    end else if (m_lives == 0) begin
    end else if (m_el >= 0) begin
      if (t) begin
        m_el++;
        if (m_el == IF) m_el = -1;
      end
    end else if (h) begin
      m_lives--;
      m_hurt = 1'b1;
      m_el   = (m_lives > 0) ? 0 : -1;
    end
  endfunction

  function automatic logic [5:0] exp_v();
    bit vis;
    vis = !((m_el >= 0) && (((m_el / BH) % 2) == 1));
    return {2'(m_lives), (m_el >= 0), vis, m_hurt, (m_lives == 0)};
  endfunction

  function automatic logic [5:0] dut_v();
    return {lives, invincible, mario_visible, hurt_pulse, game_over};
  endfunction

  task automatic cyc(input bit h, input bit t, input bit r);
    mario_hit  = h;
    frame_tick = t;
    restart    = r;
    @(posedge clk);
    m_step(h, t, r);
    #1;
    mario_hit  = 1'b0;
    frame_tick = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    checks++;
    if (dut_v() !== {2'd3, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_values: got %b required %b", dut_v(), {2'd3, 4'b0100});
    if (dut_v() !== {2'd3, 4'b0100}) errors++;
    rst_n = 1'b1;
    cyc(0, 0, 0);
    checks++;
    if (dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL reset_release: got %b required %b", dut_v(), exp_v());
    end
  endtask

  task automatic test_one_hit();
    int n_off = 0;
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    checks++;
    if (lives !== 2'd2 || hurt_pulse !== 1'b1 || invincible !== 1'b1) begin
      errors++;
      $display("FAIL one_hit_first: got lives=%0d hurt=%b inv=%b required 2 1 1",
               lives, hurt_pulse, invincible);
    end
    for (int i = 0; i < 200; i++) begin
      cyc(0, (i % 2) == 0, 0);
      if (invincible && !mario_visible) n_off++;
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL one_hit_c%0d: got %b required %b", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (n_off !== 88 || invincible !== 1'b0 || lives !== 2'd2) begin
      errors++;
      $display("FAIL one_hit_blink: got off=%0d inv=%b lives=%0d required 88 0 2",
               n_off, invincible, lives);
    end
  endtask

  task automatic test_three_hits();
    int n_hurt = 0;
    cyc(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      checks++;
      if (lives !== 2'(2 - k) || dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL three_hits_h%0d: got %b required %b", k, dut_v(), exp_v());
      end
      for (int i = 0; i < 200; i++) begin
        cyc(0, (i % 2) == 0, 0);
        checks++;
        if (dut_v() !== exp_v()) begin
          errors++;
          $display("FAIL three_hits_k%0d_c%0d: got %b required %b", k, i, dut_v(), exp_v());
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      cyc((i % 3) == 0, (i % 2) == 0, 0);
      if (hurt_pulse) n_hurt++;
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL over_hold_c%0d: got %b required %b", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (game_over !== 1'b1 || lives !== 2'd0 || n_hurt !== 0) begin
      errors++;
      $display("FAIL over_state: got go=%b lives=%0d hurts=%0d required 1 0 0",
               game_over, lives, n_hurt);
    end
  endtask

  task automatic test_hits_in_invuln();
    int nt = 0;
    int n_hurt = 0;
    bit t, h;
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    for (int i = 0; i < 200; i++) begin
      t = (i % 2) == 0;
      h = (!t && (nt == 1 || nt == 30 || nt == 89)) || (t && nt == 89);
      cyc(h, t, 0);
      if (t) nt++;
      if (hurt_pulse) n_hurt++;
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL invuln_hits_c%0d: got %b required %b", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (n_hurt !== 0 || lives !== 2'd2 || invincible !== 1'b0) begin
      errors++;
      $display("FAIL invuln_hits_end: got hurts=%0d lives=%0d inv=%b required 0 2 0",
               n_hurt, lives, invincible);
    end
  endtask

  task automatic test_restart();
    cyc(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      for (int i = 0; i < 182; i++) cyc(0, (i % 2) == 0, 0);
    end
    checks++;
    if (game_over !== 1'b1) begin
      errors++;
      $display("FAIL restart_setup: got go=%b required 1", game_over);
    end
    cyc(0, 1, 1);
    checks++;
    if (dut_v() !== {2'd3, 4'b0100} || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL restart_over: got %b required %b", dut_v(), {2'd3, 4'b0100});
    end
    cyc(1, 1, 1);
    checks++;
    if (dut_v() !== {2'd3, 4'b0100} || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL restart_hit: got %b required %b", dut_v(), {2'd3, 4'b0100});
    end
  endtask

  task automatic test_async_reset();
    int nt = 0;
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    while (nt < 45) begin
      cyc(0, 1, 0);
      nt++;
      cyc(0, 0, 0);
    end
    checks++;
    if (invincible !== 1'b1 || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL async_setup: got %b required %b", dut_v(), exp_v());
    end
    #5;
    rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (dut_v() !== {2'd3, 4'b0100}) begin
      errors++;
      $display("FAIL async_reset_now: got %b required %b", dut_v(), {2'd3, 4'b0100});
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_v() !== {2'd3, 4'b0100}) begin
      errors++;
      $display("FAIL async_reset_hold: got %b required %b", dut_v(), {2'd3, 4'b0100});
    end
    #3;
    rst_n = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    checks++;
    if (lives !== 2'd2 || dut_v() !== exp_v()) begin
      errors++;
      $display("FAIL async_after_hit: got %b required %b", dut_v(), exp_v());
    end
  endtask

  task automatic test_back_to_back();
    int n_hurt = 0;
    cyc(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(i < 2, 0, 0);
      if (hurt_pulse) n_hurt++;
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL b2b_c%0d: got %b required %b", i, dut_v(), exp_v());
      end
    end
    checks++;
    if (n_hurt !== 1 || lives !== 2'd2) begin
      errors++;
      $display("FAIL b2b_count: got hurts=%0d lives=%0d required 1 2", n_hurt, lives);
    end
  endtask

  task automatic test_random();
    bit h, t, r;
    cyc(0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      h = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 499) == 0);
      cyc(h, t, r);
      checks++;
      if (dut_v() !== exp_v()) begin
        errors++;
        $display("FAIL random_c%0d: got %b required %b", i, dut_v(), exp_v());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_one_hit();
    test_three_hits();
    test_hits_in_invuln();
    test_restart();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
